// File: rtl/conv2x2_pkg.sv
// rtl/conv2x2_pkg.sv - shared sizes, state encoding and data types for the 2x2 convolution engine
// Purpose: single source of truth for pixel/weight widths, burst geometry and
//          the packed row/kernel layouts used by the engine and its MAC.
// Ports:   none (package).
package conv2x2_pkg;

  localparam int PIX_W = 3;                    // pixel and weight width, unsigned
  localparam int IMG   = 6;                    // image side and kernels per burst
  localparam int OUT_W = 8;                    // result width, 4*7*7 = 196 fits
  localparam int N_POS = (IMG - 1) * (IMG - 1); // valid positions per kernel
  localparam int N_OUT = IMG * N_POS;          // results per burst

  localparam logic [2:0] LAST_BEAT = 3'(IMG - 1);
  localparam logic [2:0] LAST_POS  = 3'(IMG - 2);
  localparam logic [7:0] LAST_OUT  = 8'(N_OUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PRIME = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Index 0..3 = w00, w01, w10, w11, matching the in_kernel bit layout.
  typedef logic [3:0][PIX_W-1:0] kernel_t;

  // Index c = pixel column c, matching the in_row bit layout.
  typedef logic [IMG-1:0][PIX_W-1:0] row_t;

endpackage

// File: rtl/conv2x2_mac.sv
// rtl/conv2x2_mac.sv - combinational 4-tap multiply-accumulate for one 2x2 window
// Purpose: sum of four unsigned pixel*weight products.
// Ports:   p00_i..p11_i  window pixels (row, column)
//          w_i           kernel weights w00, w01, w10, w11
//          sum_o         OUT_W-bit sum, never saturates
module conv2x2_mac
  import conv2x2_pkg::*;
(
  input  logic [PIX_W-1:0] p00_i,
  input  logic [PIX_W-1:0] p01_i,
  input  logic [PIX_W-1:0] p10_i,
  input  logic [PIX_W-1:0] p11_i,
  input  kernel_t          w_i,
  output logic [OUT_W-1:0] sum_o
);

  logic [2*PIX_W-1:0] m00;
  logic [2*PIX_W-1:0] m01;
  logic [2*PIX_W-1:0] m10;
  logic [2*PIX_W-1:0] m11;

  always_comb begin
    m00   = p00_i * w_i[0];
    m01   = p01_i * w_i[1];
    m10   = p10_i * w_i[2];
    m11   = p11_i * w_i[3];
    // Widen before adding so the carries out of the 6-bit products survive.
    sum_o = OUT_W'(m00) + OUT_W'(m01) + OUT_W'(m10) + OUT_W'(m11);
  end

endmodule

// File: rtl/conv2x2_engine.sv
// rtl/conv2x2_engine.sv - 6x6 image, six 2x2 kernels, 150-result convolution engine
// Purpose: load a 6-beat burst (image row + kernel per beat), then stream
//          the 150 results kernel-major, row, column.
// Ports:   clk1       sole clock
//          rst        synchronous active-high reset
//          in_valid   burst beat strobe, 6 consecutive cycles
//          in_row     image row b, pixel c at [3c+2:3c]
//          in_kernel  kernel b, w00 [2:0] w01 [5:3] w10 [8:6] w11 [11:9]
//          out_valid  high for 150 consecutive cycles per burst
//          out_data   result, zero whenever out_valid is low
module conv2x2_engine
  import conv2x2_pkg::*;
(
  input  logic                   clk1,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [IMG*PIX_W-1:0]   in_row,
  input  logic [4*PIX_W-1:0]     in_kernel,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       out_data
);

  state_e           state_q, state_d;
  logic [2:0]       beat_q, beat_d;
  logic [2:0]       k_q, k_d;
  logic [2:0]       r_q, r_d;
  logic [2:0]       c_q, c_d;
  logic [7:0]       out_cnt_q, out_cnt_d;
  row_t             img_q [IMG];
  row_t             img_d [IMG];
  kernel_t          ker_q [IMG];
  kernel_t          ker_d [IMG];
  logic [OUT_W-1:0] res_q, res_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  row_t             row_top;
  row_t             row_bot;
  logic [OUT_W-1:0] mac_sum;

  assign row_top = img_q[r_q];
  assign row_bot = img_q[r_q + 3'd1];

  conv2x2_mac u_mac (
    .p00_i (row_top[c_q]),
    .p01_i (row_top[c_q + 3'd1]),
    .p10_i (row_bot[c_q]),
    .p11_i (row_bot[c_q + 3'd1]),
    .w_i   (ker_q[k_q]),
    .sum_o (mac_sum)
  );

  // The position counters run one result ahead of out_data: res_q holds the
  // result for the next beat of the stream while the MAC works on the one after.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    k_d       = k_q;
    r_d       = r_q;
    c_d       = c_q;
    out_cnt_d = out_cnt_q;
    img_d     = img_q;
    ker_d     = ker_q;
    res_d     = res_q;
    valid_d   = 1'b0;
    data_d    = '0;

    if (state_q == PRIME || state_q == OUT) begin
      res_d = mac_sum;
      if (c_q == LAST_POS) begin
        c_d = '0;
        if (r_q == LAST_POS) begin
          r_d = '0;
          k_d = (k_q == LAST_BEAT) ? 3'd0 : k_q + 3'd1;
        end else begin
          r_d = r_q + 3'd1;
        end
      end else begin
        c_d = c_q + 3'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          img_d[0] = in_row;
          ker_d[0] = in_kernel;
          beat_d   = 3'd1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          img_d[beat_q] = in_row;
          ker_d[beat_q] = in_kernel;
          beat_d        = beat_q + 3'd1;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = PRIME;
          end
        end else begin
          // Short burst: drop it, the partial buffer contents are never read.
          beat_d  = '0;
          state_d = IDLE;
        end
      end
      PRIME: begin
        out_cnt_d = '0;
        state_d   = OUT;
      end
      OUT: begin
        valid_d   = 1'b1;
        data_d    = res_q;
        out_cnt_d = out_cnt_q + 8'd1;
        if (out_cnt_q == LAST_OUT) begin
          out_cnt_d = '0;
          k_d       = '0;
          r_d       = '0;
          c_d       = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      k_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      out_cnt_q <= '0;
      res_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      for (int i = 0; i < IMG; i++) begin
        img_q[i] <= '0;
        ker_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      k_q       <= k_d;
      r_q       <= r_d;
      c_q       <= c_d;
      out_cnt_q <= out_cnt_d;
      res_q     <= res_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      img_q     <= img_d;
      ker_q     <= ker_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_conv2x2_engine.sv
// tb/tb_conv2x2_engine.sv - directed self-checking bench for conv2x2_engine
module tb_conv2x2_engine;

  logic        clk1      = 1'b0;
  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic [17:0] in_row    = '0;
  logic [11:0] in_kernel = '0;
  logic        out_valid;
  logic [7:0]  out_data;

  int errors = 0;
  int checks = 0;

  logic [2:0] pix [6][6];
  logic [2:0] kw  [6][4];

  conv2x2_engine dut (
    .clk1      (clk1),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_row    (in_row),
    .in_kernel (in_kernel),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk1 = ~clk1;

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  task automatic check_idle(input string tag);
    checks++;
    assert ({out_valid, out_data} === 9'h000)
    else begin
      errors++;
      $error("FAIL %s: out_valid=%0b out_data=%0d, expected 0/0", tag, out_valid, out_data);
    end
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        case (mode)
          0:       pix[r][c] = 3'd7;
          1:       pix[r][c] = 3'd1;
          2:       pix[r][c] = 3'((r + c) % 8);
          3:       pix[r][c] = 3'((3 * r + 5 * c + 1) % 8);
          4:       pix[r][c] = 3'((7 * r + c * c) % 8);
          default: pix[r][c] = 3'(((r ^ c) + 2) % 8);
        endcase
    for (int k = 0; k < 6; k++)
      for (int w = 0; w < 4; w++)
        case (mode)
          0:       kw[k][w] = 3'd7;
          1:       kw[k][w] = 3'(k);
          2:       kw[k][w] = (k == 0 && w == 0) ? 3'd1 : 3'd0;
          3:       kw[k][w] = 3'((k * 3 + w * 2 + 1) % 8);
          4:       kw[k][w] = 3'((7 - k + w) % 8);
          default: kw[k][w] = 3'((k + w * 5) % 8);
        endcase
  endtask

  // mode 0: reference sum from the loaded arrays; 1..3: hand-derived constants
  function automatic int exp_val(input int mode, input int k, input int r, input int c);
    case (mode)
      1:       return 196;
      2:       return 4 * k;
      3:       return (k == 0) ? (r + c) % 8 : 0;
      default: return kw[k][0] * pix[r][c]   + kw[k][1] * pix[r][c+1]
                    + kw[k][2] * pix[r+1][c] + kw[k][3] * pix[r+1][c+1];
    endcase
  endfunction

  task automatic send_burst(input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      in_valid = 1'b1;
      for (int c = 0; c < 6; c++) in_row[3*c +: 3] = pix[b][c];
      for (int w = 0; w < 4; w++) in_kernel[3*w +: 3] = kw[b][w];
      check_idle("load_beat");
      tick;
    end
    in_valid  = 1'b0;
    in_row    = '0;
    in_kernel = '0;
  endtask

  // Entered 1ns after the last beat edge T; output i must appear at T+2+i.
  task automatic check_stream(input int mode, input int last_idx, input string tag);
    tick;
    check_idle({tag, "_latency"});
    for (int i = 0; i <= last_idx; i++) begin
      int k;
      int r;
      int c;
      logic [7:0] e;
      k = i / 25;
      r = (i % 25) / 5;
      c = i % 5;
      e = 8'(exp_val(mode, k, r, c));
      tick;
      checks++;
      assert (out_valid === 1'b1 && out_data === e)
      else begin
        errors++;
        $error("FAIL %s_out[%0d] k%0d r%0d c%0d: valid=%0b data=%0d, expected valid=1 data=%0d",
               tag, i, k, r, c, out_valid, out_data, e);
      end
    end
    if (last_idx == 149) begin
      tick;
      check_idle({tag, "_end"});
    end
  endtask

  initial begin
    rst = 1'b1;
    tick;
    tick;
    check_idle("reset");
    rst = 1'b0;
    tick;
    check_idle("post_reset");

    fill(0);
    send_burst(6);
    check_stream(1, 149, "all7");

    fill(1);
    send_burst(6);
    check_stream(2, 149, "kramp");

    fill(2);
    send_burst(6);
    check_stream(3, 149, "ident");

    fill(3);
    send_burst(3);
    for (int i = 0; i < 20; i++) begin
      check_idle("short_burst");
      tick;
    end
    send_burst(6);
    check_stream(0, 149, "after_short");

    fill(4);
    send_burst(6);
    check_stream(0, 70, "rst_mid");
    rst = 1'b1;
    tick;
    check_idle("rst_abort");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      check_idle("rst_idle");
    end
    fill(5);
    send_burst(6);
    check_stream(0, 149, "after_rst");

    fill(3);
    send_burst(6);
    check_stream(0, 149, "b2b_a");
    fill(4);
    send_burst(6);
    check_stream(0, 149, "b2b_b");
    for (int i = 0; i < 4; i++) begin
      tick;
      check_idle("final_idle");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
